// File: rtl/clk_div_gen.sv
// Programmable glitch-free clock divider: clk_out is a flop output whose high
// and low phases each last cur_div+1 fabric cycles, with changes only at phase boundaries.
module clk_div_gen #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             rise,
    output logic             load_ack,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] cur_div;
    logic [WIDTH-1:0] cur_div_nxt;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] pend_div_nxt;
    logic             pend_valid;
    logic             pend_valid_nxt;
    logic             clk_out_nxt;
    logic             rise_nxt;
    logic             load_ack_nxt;
    logic             phase_end;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_div    <= WIDTH'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            clk_out    <= 1'b0;
            rise       <= 1'b0;
            load_ack   <= 1'b0;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            cur_div    <= cur_div_nxt;
            pend_div   <= pend_div_nxt;
            pend_valid <= pend_valid_nxt;
            clk_out    <= clk_out_nxt;
            rise       <= rise_nxt;
            load_ack   <= load_ack_nxt;
            running    <= (state_nxt != IDLE);
        end
    end

    assign phase_end = (cnt == cur_div);

    // Next-state, counter and divisor bookkeeping
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        cur_div_nxt    = cur_div;
        pend_div_nxt   = pend_div;
        pend_valid_nxt = pend_valid;
        clk_out_nxt    = 1'b0;
        rise_nxt       = 1'b0;
        load_ack_nxt   = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (div_load) begin
                    cur_div_nxt  = div_in;
                    load_ack_nxt = 1'b1;
                end
                if (en) begin
                    state_nxt   = HIGH;
                    clk_out_nxt = 1'b1;
                    rise_nxt    = 1'b1;
                end
            end

            HIGH: begin
                clk_out_nxt = 1'b1;
                cnt_nxt     = cnt + WIDTH'(1);
                if (div_load) begin
                    pend_div_nxt   = div_in;
                    pend_valid_nxt = 1'b1;
                end
                if (phase_end) begin
                    state_nxt   = LOW;
                    clk_out_nxt = 1'b0;
                    cnt_nxt     = '0;
                end
            end

            LOW: begin
                cnt_nxt = cnt + WIDTH'(1);
                if (phase_end) begin
                    // End of period: a same-cycle load beats an older pending one
                    cnt_nxt        = '0;
                    pend_valid_nxt = 1'b0;
                    if (div_load) begin
                        cur_div_nxt  = div_in;
                        load_ack_nxt = 1'b1;
                    end else if (pend_valid) begin
                        cur_div_nxt  = pend_div;
                        load_ack_nxt = 1'b1;
                    end
                    if (en) begin
                        state_nxt   = HIGH;
                        clk_out_nxt = 1'b1;
                        rise_nxt    = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (div_load) begin
                    pend_div_nxt   = div_in;
                    pend_valid_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule
